// File: rtl/bus_arbiter.sv
// Two-master / one-slave peripheral bus arbiter with read timeout.
// Define BUS_ARB_RR_EN for round-robin tie-breaking; default is fixed priority (m0 wins).
//
// Handshake: a master request is the level rd_en|wr_en, held (with addr/wr_data stable)
// until the one-cycle ack pulse; the slave sees a one-cycle s_rd_en/s_wr_en strobe and
// answers reads with a one-cycle s_rd_valid, which is only honoured in WAIT.
module bus_arbiter #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] m0_addr,
  input  logic        m0_rd_en,
  input  logic        m0_wr_en,
  input  logic [31:0] m0_wr_data,
  output logic [31:0] m0_rd_data,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic [15:0] m1_addr,
  input  logic        m1_rd_en,
  input  logic        m1_wr_en,
  input  logic [31:0] m1_wr_data,
  output logic [31:0] m1_rd_data,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [15:0] s_addr,
  output logic        s_rd_en,
  output logic        s_wr_en,
  output logic [31:0] s_wr_data,
  input  logic [31:0] s_rd_data,
  input  logic        s_rd_valid,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, next_state;
  logic        last_grant, nxt_last_grant;   // 0 = m0, 1 = m1
  logic        is_wr, nxt_is_wr;
  logic [7:0]  cnt, nxt_cnt;
  logic [7:0]  cnt_inc;

  logic [15:0] nxt_s_addr;
  logic        nxt_s_rd_en, nxt_s_wr_en;
  logic [31:0] nxt_s_wr_data;
  logic [1:0]  nxt_grant;
  logic        nxt_busy;
  logic [31:0] nxt_m0_rd_data, nxt_m1_rd_data;
  logic        nxt_m0_ack, nxt_m0_err, nxt_m1_ack, nxt_m1_err;

  logic        req0, req1, pick_m1, pick_wr;
  logic        complete, resp_rd, resp_err;
  logic [31:0] resp_data;

  assign req0      = m0_rd_en | m0_wr_en;
  assign req1      = m1_rd_en | m1_wr_en;
  assign cnt_inc   = cnt + 8'd1;
  assign dbg_state = state;

`ifdef BUS_ARB_RR_EN
  // On a tie, m1 wins only if m0 was served last.
  assign pick_m1 = req1 & (~req0 | ~last_grant);
`else
  assign pick_m1 = req1 & ~req0;
`endif

  // Write has precedence when a master raises both rd_en and wr_en.
  assign pick_wr = pick_m1 ? m1_wr_en : m0_wr_en;

  always_comb begin
    next_state     = state;
    nxt_last_grant = last_grant;
    nxt_is_wr      = is_wr;
    nxt_cnt        = cnt;
    nxt_s_addr     = 16'h0000;
    nxt_s_rd_en    = 1'b0;
    nxt_s_wr_en    = 1'b0;
    nxt_s_wr_data  = s_wr_data;
    nxt_grant      = grant;
    nxt_m0_rd_data = m0_rd_data;
    nxt_m1_rd_data = m1_rd_data;
    nxt_m0_ack     = 1'b0;
    nxt_m0_err     = 1'b0;
    nxt_m1_ack     = 1'b0;
    nxt_m1_err     = 1'b0;
    complete       = 1'b0;
    resp_rd        = 1'b0;
    resp_err       = 1'b0;
    resp_data      = 32'h0000_0000;

    case (state)
      IDLE: begin
        if (req0 | req1) begin
          next_state    = ISSUE;
          nxt_grant     = pick_m1 ? 2'b10 : 2'b01;
          nxt_s_addr    = pick_m1 ? m1_addr : m0_addr;
          nxt_s_wr_data = pick_m1 ? m1_wr_data : m0_wr_data;
          nxt_is_wr     = pick_wr;
          nxt_s_wr_en   = pick_wr;
          nxt_s_rd_en   = ~pick_wr;
        end
      end
      ISSUE: begin
        if (is_wr) begin
          next_state = RESP;
          complete   = 1'b1;
        end else begin
          next_state = WAIT;
          nxt_cnt    = 8'd0;
        end
      end
      WAIT: begin
        // Valid data takes precedence over a timeout expiring in the same cycle.
        if (s_rd_valid) begin
          next_state = RESP;
          complete   = 1'b1;
          resp_rd    = 1'b1;
          resp_data  = s_rd_data;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          next_state = RESP;
          complete   = 1'b1;
          resp_rd    = 1'b1;
          resp_err   = 1'b1;
          resp_data  = ERR_DATA;
          nxt_cnt    = cnt_inc;
        end else begin
          nxt_cnt = cnt_inc;
        end
      end
      RESP: begin
        next_state     = IDLE;
        nxt_last_grant = grant[1];
        nxt_grant      = 2'b00;
      end
      default: begin
        next_state = IDLE;
        nxt_grant  = 2'b00;
      end
    endcase

    if (complete) begin
      if (grant[0]) begin
        nxt_m0_ack = 1'b1;
        nxt_m0_err = resp_err;
        if (resp_rd) nxt_m0_rd_data = resp_data;
      end
      if (grant[1]) begin
        nxt_m1_ack = 1'b1;
        nxt_m1_err = resp_err;
        if (resp_rd) nxt_m1_rd_data = resp_data;
      end
    end

    nxt_busy = (next_state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      is_wr      <= 1'b0;
      cnt        <= 8'd0;
      s_addr     <= 16'h0000;
      s_rd_en    <= 1'b0;
      s_wr_en    <= 1'b0;
      s_wr_data  <= 32'h0000_0000;
      grant      <= 2'b00;
      busy       <= 1'b0;
      m0_rd_data <= 32'h0000_0000;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m1_rd_data <= 32'h0000_0000;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      state      <= next_state;
      last_grant <= nxt_last_grant;
      is_wr      <= nxt_is_wr;
      cnt        <= nxt_cnt;
      s_addr     <= nxt_s_addr;
      s_rd_en    <= nxt_s_rd_en;
      s_wr_en    <= nxt_s_wr_en;
      s_wr_data  <= nxt_s_wr_data;
      grant      <= nxt_grant;
      busy       <= nxt_busy;
      m0_rd_data <= nxt_m0_rd_data;
      m0_ack     <= nxt_m0_ack;
      m0_err     <= nxt_m0_err;
      m1_rd_data <= nxt_m1_rd_data;
      m1_ack     <= nxt_m1_ack;
      m1_err     <= nxt_m1_err;
    end
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-master, one-slave arbiter for the 16-bit-address / 32-bit-data peripheral bus. It shares the RAM/LED/UART decode fabric between the CPU (m0) and a second requester such as a DMA or debug loader (m1). It serialises transactions and turns the slave's strobe/rd_valid protocol into a per-master request/ack handshake. It also bounds read latency with a timeout.

Parameters:
TIMEOUT, 16, max cycles spent in WAIT for s_rd_valid before an error completion (1..255)
ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
m0_addr  in  16  master 0 address, held stable while request is pending
m0_rd_en  in  1  master 0 read request (level, held until m0_ack)
m0_wr_en  in  1  master 0 write request (level, held until m0_ack)
m0_wr_data  in  32  master 0 write data
m0_rd_data  out  32  master 0 read data, valid when m0_ack=1
m0_ack  out  1  master 0 one-cycle completion pulse
m0_err  out  1  master 0 timeout flag, only high together with m0_ack
m1_*  same seven ports as m0_*, for master 1
s_addr  out  16  slave address
s_rd_en  out  1  slave read strobe
s_wr_en  out  1  slave write strobe
s_wr_data  out  32  slave write data
s_rd_data  in  32  slave read data
s_rd_valid  in  1  slave read data valid
grant  out  2  one-hot owner of current transaction, 0 when idle
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. On reset: all outputs 0, state=IDLE, last_grant=m1 (so m0 wins the first tie), timeout counter 0.
- Request: a master has a request when rd_en|wr_en=1. If both are set, the transaction is a write.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is present, pick the winner (policy below), latch its addr, wr_data and direction, set grant, go to ISSUE.
  - s_rd_valid is ignored in IDLE.
- ISSUE (exactly 1 cycle):
  - Drive s_addr and s_wr_data from the latched values. Assert s_wr_en or s_rd_en for this cycle only.
  - Write: go to RESP.
  - Read: clear the counter and go to WAIT.
- WAIT:
  - When s_rd_valid=1, capture s_rd_data and go to RESP with err=0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to RESP with data=ERR_DATA and err=1.
  - If s_rd_valid arrives in the same cycle the counter hits TIMEOUT, the valid data wins.
- RESP (exactly 1 cycle):
  - The granted master's ack=1, with rd_data and err.
  - The non-granted master's ack=0; its rd_data holds its previous value.
  - Update last_grant, clear grant, go to IDLE.
  - s_addr, s_rd_en and s_wr_en are low in every state except ISSUE. s_addr and s_wr_data may hold their last value.
- Latency, with the request first seen in cycle N:
  - s_*_en is high in N+1.
  - Write ack in N+2.
  - Read with 1-cycle slave: s_rd_valid in N+2, ack in N+3.
  - Timeout read: ack in N+2+TIMEOUT.
- Master rule: deassert the request in the cycle after ack. The arbiter re-samples requests in IDLE (N+3 for writes). A still-asserted request there is a new transaction.
- Peak throughput: one write per 3 cycles, one read per 4 cycles.
- Reset mid-operation: abort immediately to IDLE. No ack is issued, strobes drop, and a late s_rd_valid is ignored.
- Address and data are passed unmodified. Byte-lane selection and address decode are downstream.

Optional Feature:
Macro: BUS_ARB_RR_EN
- Defined: round-robin. On a tie in IDLE, grant the master that was not last_grant. A lone requester always wins.
- Undefined: fixed priority, m0 always wins a tie. last_grant is still maintained but unused. m1 can starve under continuous m0 traffic; this is accepted.

Test Plan:
- m0 write addr 0x4000 data 0x00000001 -> s_wr_en high 1 cycle at N+1 with s_addr=0x4000 and s_wr_data=0x1; m0_ack=1 at N+2; m0_err=0; grant=2'b01 during N+1..N+2.
- m1 read 0x0010, slave returns 0x12345678 one cycle after s_rd_en -> m1_ack=1 and m1_rd_data=0x12345678 at N+3; m0_ack stays 0.
- m0 and m1 issue continuous back-to-back reads -> with BUS_ARB_RR_EN grants alternate m0, m1, m0, m1; without it m0 is granted every time.
- m0 read to unmapped 0xC000 (slave never asserts valid), TIMEOUT=16 -> m0_ack=1, m0_err=1, m0_rd_data=0xDEADBEEF exactly 18 cycles after the request; s_rd_valid asserted on the timeout cycle instead returns the slave data with err=0.
- rst asserted during WAIT of an m1 read -> next cycle all outputs 0 and busy=0; s_rd_valid the following cycle produces no m1_ack; the next m0 and m1 tie is granted to m0.
- m0 holds rd_en and wr_en together, data 0xA5A5A5A5 -> write performed (s_wr_en=1, s_rd_en=0); ack at N+2.
